// File: rtl/weight_mem_ctrl.sv
// weight_mem_ctrl: loads a stream of 16-bit weights into the weight memory,
// then issues row reads (3 or 8 words per row) to the consumer.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; config is checked and latched here
// LOAD   | accepting words; with in_ready low, the last write drains
// READ   | presenting one row at a time until rd_ready takes it
// DONE   | one-cycle done pulse, then back to IDLE
module weight_mem_ctrl #(
    parameter int MAX_WEIGHT_NUM = 580,
    parameter int ADDR_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [15:0]       cfg_weight_total,
    input  logic [15:0]       cfg_row_total,
    input  logic [4:0]        cfg_mode,
    input  logic              in_valid,
    input  logic [15:0]       in_data,
    output logic              in_ready,
    output logic              write_weight_signal,
    output logic [ADDR_W-1:0] write_weight_addr,
    output logic [15:0]       write_weight_data,
    output logic              read_weight_signal,
    output logic [ADDR_W-1:0] read_weight_addr,
    output logic [4:0]        buffer_num_sel,
    input  logic              rd_ready,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_READ = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [31:0] MAX_W = 32'(MAX_WEIGHT_NUM);

    state_t              state_q, state_d;
    logic [15:0]         wtot_q, wtot_d;
    logic [15:0]         rtot_q, rtot_d;
    logic [4:0]          mode_q, mode_d;
    logic [15:0]         wcnt_q, wcnt_d;
    logic [15:0]         rcnt_q, rcnt_d;
    logic                in_ready_q, in_ready_d;
    logic                wr_sig_q, wr_sig_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [15:0]         wr_data_q, wr_data_d;
    logic                rd_sig_q, rd_sig_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [4:0]          sel_q, sel_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                cfg_err_q, cfg_err_d;

    logic [31:0]         words_per_row;
    logic [31:0]         words_needed;
    logic                cfg_ok;

    // Legality of the configuration presented with start: every word the
    // last row touches must have been loaded.
    always_comb begin
        words_per_row = (cfg_mode == 5'd2) ? 32'd8 : 32'd3;
        words_needed  = {16'd0, cfg_row_total} * words_per_row;
        cfg_ok = ((cfg_mode == 5'd1) || (cfg_mode == 5'd2))
              && (cfg_weight_total != 16'd0)
              && ({16'd0, cfg_weight_total} <= MAX_W)
              && (cfg_row_total != 16'd0)
              && (words_needed <= {16'd0, cfg_weight_total});
    end

    // Next-state and next-output computation; abort overrides everything.
    always_comb begin
        state_d    = state_q;
        wtot_d     = wtot_q;
        rtot_d     = rtot_q;
        mode_d     = mode_q;
        wcnt_d     = wcnt_q;
        rcnt_d     = rcnt_q;
        in_ready_d = in_ready_q;
        rd_sig_d   = rd_sig_q;
        rd_addr_d  = rd_addr_q;
        sel_d      = sel_q;
        busy_d     = busy_q;
        wr_sig_d   = 1'b0;
        wr_addr_d  = '0;
        wr_data_d  = '0;
        done_d     = 1'b0;
        cfg_err_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (cfg_ok) begin
                        state_d    = S_LOAD;
                        wtot_d     = cfg_weight_total;
                        rtot_d     = cfg_row_total;
                        mode_d     = cfg_mode;
                        wcnt_d     = '0;
                        rcnt_d     = '0;
                        in_ready_d = 1'b1;
                        busy_d     = 1'b1;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (in_ready_q) begin
                    if (in_valid) begin
                        wr_sig_d  = 1'b1;
                        wr_addr_d = ADDR_W'(wcnt_q);
                        wr_data_d = in_data;
                        wcnt_d    = wcnt_q + 16'd1;
                        if (wcnt_q == wtot_q - 16'd1) begin
                            in_ready_d = 1'b0;
                        end
                    end
                end else begin
                    // Last write is on the port this cycle; reads start after it.
                    state_d   = S_READ;
                    rd_sig_d  = 1'b1;
                    rd_addr_d = '0;
                    sel_d     = mode_q;
                    rcnt_d    = '0;
                end
            end
            S_READ: begin
                if (rd_ready && rd_sig_q) begin
                    if (rcnt_q == rtot_q - 16'd1) begin
                        state_d   = S_DONE;
                        rd_sig_d  = 1'b0;
                        rd_addr_d = '0;
                        sel_d     = '0;
                        done_d    = 1'b1;
                    end else begin
                        rcnt_d    = rcnt_q + 16'd1;
                        rd_addr_d = ADDR_W'(rcnt_q + 16'd1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                wcnt_d  = '0;
                rcnt_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d    = S_IDLE;
            wcnt_d     = '0;
            rcnt_d     = '0;
            in_ready_d = 1'b0;
            rd_sig_d   = 1'b0;
            rd_addr_d  = '0;
            sel_d      = '0;
            busy_d     = 1'b0;
            wr_sig_d   = 1'b0;
            wr_addr_d  = '0;
            wr_data_d  = '0;
            done_d     = 1'b0;
            cfg_err_d  = 1'b0;
        end
    end

    // State and registered outputs; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            wtot_q     <= '0;
            rtot_q     <= '0;
            mode_q     <= '0;
            wcnt_q     <= '0;
            rcnt_q     <= '0;
            in_ready_q <= 1'b0;
            wr_sig_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_sig_q   <= 1'b0;
            rd_addr_q  <= '0;
            sel_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wtot_q     <= wtot_d;
            rtot_q     <= rtot_d;
            mode_q     <= mode_d;
            wcnt_q     <= wcnt_d;
            rcnt_q     <= rcnt_d;
            in_ready_q <= in_ready_d;
            wr_sig_q   <= wr_sig_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_sig_q   <= rd_sig_d;
            rd_addr_q  <= rd_addr_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign in_ready            = in_ready_q;
    assign write_weight_signal = wr_sig_q;
    assign write_weight_addr   = wr_addr_q;
    assign write_weight_data   = wr_data_q;
    assign read_weight_signal  = rd_sig_q;
    assign read_weight_addr    = rd_addr_q;
    assign buffer_num_sel      = sel_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign cfg_err             = cfg_err_q;

endmodule
